uart_rx_framer: RTL and testbench
=================================

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 27, meaning CLK_BASE cycles per 1/16 bit (27 gives 115200 baud at 50 MHz).
REQ-002 SHALL have parameter PARITY_EN, default 0, meaning 1 = parity bit expected after the data bits.
REQ-003 SHALL have parameter PARITY_ODD, default 0, meaning 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-004 SHALL have port CLK_BASE  input  1  fabric clock (FAB_CCC_GL0); the only clock.
REQ-005 SHALL have port RESET_N  input  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have port MMUART_0_TXD  input  1  serial line driven by MSS MMUART_0, asynchronous to CLK_BASE, idle high.
REQ-007 SHALL have port RX_DATA  output  8  byte at FIFO head.
REQ-008 SHALL have port RX_VALID  output  1  FIFO not empty.
REQ-009 SHALL have port RX_READY  input  1  consumer accepts RX_DATA when RX_VALID=1.
REQ-010 SHALL have port RX_BUSY  output  1  high in every state except IDLE.
REQ-011 SHALL have port FRAME_ERR  output  1  one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port PARITY_ERR  output  1  one-cycle pulse on a parity mismatch.
REQ-013 SHALL have port OVERRUN  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-014 SHALL have port ERR_CNT  output  8  saturating count of FRAME_ERR, PARITY_ERR and OVERRUN events.

Function
REQ-015 SHALL pass MMUART_0_TXD through a 2-flop synchronizer; both flops reset to 1; all further references mean the synchronized value.
REQ-016 SHALL generate a 16x tick when the divider counter reaches BAUD_DIV-1; the counter then wraps to 0.
REQ-017 SHALL clear the divider counter and the sample counter (0..15) on entry to START.
REQ-018 SHALL use the FSM states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-019 SHALL transition IDLE->START when it samples line=0.
REQ-020 SHALL take each bit value as the 2-of-3 majority of the samples at sample counts 7, 8 and 9 of that bit.
REQ-021 SHALL, in START, go to DATA when the majority is 0; otherwise it SHALL return to IDLE (glitch rejected, no flag).
REQ-022 SHALL, in DATA, shift in 8 bits LSB first, then go to PARITY if PARITY_EN=1, else to STOP.
REQ-023 SHALL, in PARITY, compare the received bit with the XOR of the data bits, inverted when PARITY_ODD=1; the result is latched for use in STOP.
REQ-024 SHALL, in STOP, act on the majority at sample count 9 and not wait for the bit to end:
- Stop=1 with no parity error: push the byte and go to IDLE.
- Stop=1 with a parity error: pulse PARITY_ERR, discard the byte, go to IDLE.
- Stop=0: pulse FRAME_ERR, discard the byte, go to BREAK; PARITY_ERR is not also pulsed.
REQ-025 SHALL stay in BREAK until line=1, then go to IDLE.
REQ-026 SHALL hold received bytes in a 4-entry FIFO; RX_DATA is the head entry and is stable while RX_VALID=1 and RX_READY=0.
REQ-027 SHALL pop one entry on every cycle where RX_VALID=1 and RX_READY=1.
REQ-028 SHALL, on a push into a full FIFO with no pop in the same cycle, drop the new byte, pulse OVERRUN and leave the stored entries unchanged.
REQ-029 SHALL, on a push and a pop in the same cycle with the FIFO full, perform both, leaving the count at 4 with no OVERRUN.
REQ-030 SHALL assert RX_VALID on the cycle after the push that takes the FIFO from empty to non-empty.
REQ-031 SHALL increment ERR_CNT by the number of error pulses asserted in that cycle, saturating at 255.

Reset
REQ-032 SHALL, while RESET_N=0, hold:
- FSM in IDLE and all counters at 0.
- FIFO empty: RX_VALID=0, RX_DATA=0x00.
- RX_BUSY=0 and all error pulses 0.
- ERR_CNT=0 and synchronizer flops at 1.
REQ-033 SHALL, when reset asserts mid-frame, discard the partial frame; after release the block SHALL start only on a new falling edge.

Verification (BAUD_DIV=4, so 64 clocks per bit)
REQ-034 SHALL cover: 8N1 frame 0xA5 with RX_READY=1 -> RX_DATA=0xA5, RX_VALID high for exactly 1 cycle, no error pulses, ERR_CNT=0.
REQ-035 SHALL cover: a 16-clock low glitch on an idle line -> RX_BUSY high then low within 40 clocks, no push, no error pulses.
REQ-036 SHALL cover: frame 0x3C with stop bit 0, then line held low 200 clocks and released -> one FRAME_ERR pulse, no push, BREAK left after release, ERR_CNT=1; a following 0x55 frame is received correctly.
REQ-037 SHALL cover: bytes 0x01..0x05 sent with RX_READY=0 -> one OVERRUN pulse on 0x05; after RX_READY=1 the reads are 0x01, 0x02, 0x03, 0x04; ERR_CNT=1.
REQ-038 SHALL cover: PARITY_EN=1, PARITY_ODD=1, frame 0x07 with parity bit 1 -> PARITY_ERR pulse, no push; the same frame with parity bit 0 -> 0x07 received.
REQ-039 SHALL cover: RESET_N pulsed low during data bit 4 of 0xFF -> no output, RX_BUSY=0; the next frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_framer.sv
// UART receiver: 16x oversampled framer with majority voting, optional parity,
// break detection, a 4-entry receive FIFO and a saturating error counter.
module uart_rx_framer #(
    parameter int unsigned BAUD_DIV   = 27,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       CLK_BASE,
    input  logic       RESET_N,
    input  logic       MMUART_0_TXD,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       RX_BUSY,
    output logic       FRAME_ERR,
    output logic       PARITY_ERR,
    output logic       OVERRUN,
    output logic [7:0] ERR_CNT
);

    localparam int unsigned DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
    localparam logic PAR_ON  = (PARITY_EN != 0);
    localparam logic PAR_POL = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic             sync1_q, sync2_q, line_prev_q;
    logic             line;
    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       smp_q, smp_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             s7_q, s7_d, s8_q, s8_d;
    logic             perr_q, perr_d;
    logic             tick, mid, bit_end, maj;
    logic             push, frame_ev, parity_ev, ovr_ev;

    // Two-flop synchronizer; line_prev_q lets IDLE start only on a real falling edge.
    always_ff @(posedge CLK_BASE or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            sync1_q     <= MMUART_0_TXD;
            sync2_q     <= sync1_q;
            line_prev_q <= sync2_q;
        end
    end
    assign line = sync2_q;

    assign tick    = (div_q == DIV_LAST);
    assign mid     = tick && (smp_q == 4'd9);
    assign bit_end = tick && (smp_q == 4'd15);
    assign maj     = (s7_q & s8_q) | (s7_q & line) | (s8_q & line);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        smp_d     = smp_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        s7_d      = s7_q;
        s8_d      = s8_q;
        perr_d    = perr_q;
        push      = 1'b0;
        frame_ev  = 1'b0;
        parity_ev = 1'b0;
        if (state_q != S_IDLE && state_q != S_BREAK) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) smp_d = smp_q + 4'd1;
            if (tick && smp_q == 4'd7) s7_d = line;
            if (tick && smp_q == 4'd8) s8_d = line;
        end
        case (state_q)
            S_IDLE: begin
                if (line_prev_q && !line) begin
                    state_d = S_START;
                    div_d   = '0;
                    smp_d   = '0;
                    perr_d  = 1'b0;
                end
            end
            S_START: begin
                if (mid && maj) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (mid) shift_d = {maj, shift_q[7:1]};
                if (bit_end) begin
                    if (bit_q == 3'd7) state_d = PAR_ON ? S_PARITY : S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_PARITY: begin
                if (mid)     perr_d  = maj ^ (^shift_q) ^ PAR_POL;
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // Decide at mid-stop so a back-to-back start bit is never missed.
                if (mid) begin
                    if (!maj) begin
                        frame_ev = 1'b1;
                        state_d  = S_BREAK;
                    end else begin
                        parity_ev = perr_q;
                        push      = !perr_q;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (line) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_BASE or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            smp_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            s7_q    <= 1'b1;
            s8_q    <= 1'b1;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            smp_q   <= smp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            s7_q    <= s7_d;
            s8_q    <= s8_d;
            perr_q  <= perr_d;
        end
    end

    assign RX_BUSY = (state_q != S_IDLE);

    logic [7:0] mem_q [4];
    logic [1:0] wr_q, rd_q;
    logic [2:0] cnt_q;
    logic       pop, full, do_push;
    logic [8:0] err_sum;

    assign pop     = RX_VALID && RX_READY;
    assign full    = (cnt_q == 3'd4);
    assign do_push = push && (!full || pop);
    assign ovr_ev  = push && full && !pop;
    assign err_sum = {1'b0, ERR_CNT} + 9'(frame_ev) + 9'(parity_ev) + 9'(ovr_ev);

    always_ff @(posedge CLK_BASE or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            FRAME_ERR  <= 1'b0;
            PARITY_ERR <= 1'b0;
            OVERRUN    <= 1'b0;
            ERR_CNT    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= shift_q;
                wr_q        <= wr_q + 2'd1;
            end
            if (pop) rd_q <= rd_q + 2'd1;
            case ({do_push, pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
            FRAME_ERR  <= frame_ev;
            PARITY_ERR <= parity_ev;
            OVERRUN    <= ovr_ev;
            ERR_CNT    <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign RX_VALID = (cnt_q != 3'd0);
    assign RX_DATA  = mem_q[rd_q];

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: directed frames on an 8N1 instance and
// an odd-parity instance; monitors pop expected bytes on every accepted read.
module tb_uart_rx_framer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, line_a, line_b, ready_a, ready_b;
    logic [7:0] data_a, data_b, err_a, err_b;
    logic       valid_a, valid_b, busy_a, busy_b;
    logic       fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;

    uart_rx_framer #(.BAUD_DIV(4)) dut_a (
        .CLK_BASE(clk), .RESET_N(rst_a), .MMUART_0_TXD(line_a),
        .RX_DATA(data_a), .RX_VALID(valid_a), .RX_READY(ready_a), .RX_BUSY(busy_a),
        .FRAME_ERR(fe_a), .PARITY_ERR(pe_a), .OVERRUN(ov_a), .ERR_CNT(err_a)
    );

    uart_rx_framer #(.BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_b (
        .CLK_BASE(clk), .RESET_N(rst_b), .MMUART_0_TXD(line_b),
        .RX_DATA(data_b), .RX_VALID(valid_b), .RX_READY(ready_b), .RX_BUSY(busy_b),
        .FRAME_ERR(fe_b), .PARITY_ERR(pe_b), .OVERRUN(ov_b), .ERR_CNT(err_b)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int fe_cnt_a = 0, pe_cnt_a = 0, ov_cnt_a = 0, vcyc_a = 0, pops_a = 0, busy_cyc_a = 0;
    int fe_cnt_b = 0, pe_cnt_b = 0, ov_cnt_b = 0, pops_b = 0;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, req);
        end
    endfunction

    // Monitors: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (valid_a) vcyc_a++;
        if (busy_a) busy_cyc_a++;
        if (fe_a) fe_cnt_a++;
        if (pe_a) pe_cnt_a++;
        if (ov_a) ov_cnt_a++;
        if (valid_a && ready_a) begin
            pops_a++;
            if (exp_a.size() == 0) check("a_unexpected_pop", int'(data_a), -1);
            else check("a_rx_data", int'(data_a), int'(exp_a.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (fe_b) fe_cnt_b++;
        if (pe_b) pe_cnt_b++;
        if (ov_b) ov_cnt_b++;
        if (valid_b && ready_b) begin
            pops_b++;
            if (exp_b.size() == 0) check("b_unexpected_pop", int'(data_b), -1);
            else check("b_rx_data", int'(data_b), int'(exp_b.pop_front()));
        end
    end

    task automatic send_bit(input bit which, input logic v);
        if (which) line_b = v;
        else       line_a = v;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_frame(input bit which, input logic [7:0] b, input bit par_en,
                              input logic par, input logic stop);
        send_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(which, b[i]);
        if (par_en) send_bit(which, par);
        send_bit(which, stop);
        if (stop) repeat (16) @(negedge clk);
    endtask

    task automatic drain(input bit which);
        for (int i = 0; i < 300; i++) begin
            if ((which ? exp_b.size() : exp_a.size()) == 0) break;
            @(negedge clk);
        end
        check(which ? "b_drain" : "a_drain", which ? exp_b.size() : exp_a.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        bit fell;
        rst_a = 1'b0; rst_b = 1'b0;
        line_a = 1'b1; line_b = 1'b1;
        ready_a = 1'b1; ready_b = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(valid_a), 0);
        check("rst_data", int'(data_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_err_cnt", int'(err_a), 0);
        check("rst_pulses", int'({fe_a, pe_a, ov_a}), 0);
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (10) @(negedge clk);

        // 8N1 0xA5, consumer always ready
        vcyc_a = 0; pops_a = 0;
        exp_a.push_back(8'hA5);
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        drain(1'b0);
        check("t1_valid_cycles", vcyc_a, 1);
        check("t1_pops", pops_a, 1);
        check("t1_err_pulses", fe_cnt_a + pe_cnt_a + ov_cnt_a, 0);
        check("t1_err_cnt", int'(err_a), 0);

        // 16-clock glitch on idle line
        pops_a = 0; seen = 1'b0; fell = 1'b0;
        line_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (busy_a) seen = 1'b1;
        end
        line_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy_a) begin
                fell = 1'b1;
                break;
            end
        end
        check("t2_busy_rose", int'(seen), 1);
        check("t2_busy_fell", int'(fell), 1);
        repeat (64) @(negedge clk);
        check("t2_pops", pops_a, 0);
        check("t2_err_pulses", fe_cnt_a + pe_cnt_a + ov_cnt_a, 0);

        // 0x3C with bad stop bit, then a long break
        pops_a = 0; fell = 1'b0;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        check("t3_busy_in_break", int'(busy_a), 1);
        line_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!busy_a) begin
                fell = 1'b1;
                break;
            end
        end
        check("t3_break_exit", int'(fell), 1);
        check("t3_frame_err", fe_cnt_a, 1);
        check("t3_parity_err", pe_cnt_a, 0);
        check("t3_pops", pops_a, 0);
        check("t3_err_cnt", int'(err_a), 1);
        repeat (64) @(negedge clk);
        exp_a.push_back(8'h55);
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        drain(1'b0);
        check("t3_pops_after", pops_a, 1);

        // Overrun: five bytes into a 4-deep FIFO with consumer stalled
        reset_a();
        ready_a = 1'b0; pops_a = 0; ov_cnt_a = 0;
        for (int b = 1; b <= 4; b++) begin
            exp_a.push_back(8'(b));
            send_frame(1'b0, 8'(b), 1'b0, 1'b0, 1'b1);
        end
        check("t4_ovr_before", ov_cnt_a, 0);
        send_frame(1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
        check("t4_ovr_on_5", ov_cnt_a, 1);
        check("t4_head_stable", int'(data_a), 8'h01);
        check("t4_valid_held", int'(valid_a), 1);
        ready_a = 1'b1;
        drain(1'b0);
        check("t4_pops", pops_a, 4);
        check("t4_valid_empty", int'(valid_a), 0);
        check("t4_err_cnt", int'(err_a), 1);

        // Odd parity: 0x07 needs parity bit 0
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        check("t5_parity_err", pe_cnt_b, 1);
        check("t5_frame_err", fe_cnt_b, 0);
        check("t5_pops_bad", pops_b, 0);
        exp_b.push_back(8'h07);
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        drain(1'b1);
        check("t5_pops_good", pops_b, 1);
        check("t5_parity_err_after", pe_cnt_b, 1);
        check("t5_err_cnt", int'(err_b), 1);
        check("t5_overrun", ov_cnt_b, 0);

        // Reset during data bit 4 of 0xFF
        pops_a = 0;
        fork
            send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
            begin
                repeat (64 + 4 * 64 + 32) @(negedge clk);
                rst_a = 1'b0;
                repeat (4) @(negedge clk);
                rst_a = 1'b1;
                busy_cyc_a = 0;
            end
        join
        check("t6_busy_after_rst", busy_cyc_a, 0);
        check("t6_pops", pops_a, 0);
        check("t6_busy_now", int'(busy_a), 0);
        exp_a.push_back(8'h81);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        drain(1'b0);
        check("t6_pops_after", pops_a, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
